// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiplier / restoring divider with HI/LO
// registers and a start/busy/done handshake.
// Optional feature macro: ALU_MULDIV_DIV_EN (divider datapath, DIV/DIVU).
// Without it DIV/DIVU are reported through ill like reserved opcodes.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ill,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc;       // {partial product | remainder, multiplier | dividend/quotient}
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic            sign_q;

  logic            op_mul, op_div, op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]  mul_sum;
  logic [DW-1:0]   acc_next;
  logic [DW-1:0]   prod;

`ifdef ALU_MULDIV_DIV_EN
  logic            is_mul, sign_r, div_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]  div_shift;
  logic            div_ge;
  logic [WIDTH-1:0] div_sub, q_fix, r_fix;
`endif

  assign zero = (lo == '0);

  // Opcode decode and operand magnitudes for the accept cycle.
  always_comb begin
    op_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_MULDIV_DIV_EN
    op_div = (op == OP_DIV) || (op == OP_DIVU);
`else
    op_div = 1'b0;
`endif
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_mag = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // One iteration step plus sign correction of the finished magnitudes.
  always_comb begin
    mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    prod     = sign_q ? (~acc + DW'(1)) : acc;
`ifdef ALU_MULDIV_DIV_EN
    // Remainder is always below the divisor, so a WIDTH-bit subtract is exact
    // whenever the trial succeeds.
    div_shift = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    if (is_mul)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_ge)
      acc_next = {div_sub, acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    q_fix = sign_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    r_fix = sign_r ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
`else
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`endif
  end

  // Control FSM, iteration registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      sign_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      ill      <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      is_mul   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
`endif
    end else begin
      done <= 1'b0;
      ill  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_mul || op_div) begin
              acc    <= {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
              opnd   <= op_mul ? a_mag : b_mag;
              sign_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MULDIV_DIV_EN
              is_mul   <= op_mul;
              sign_r   <= op_signed && a[WIDTH-1];
              div_zero <= op_div && (b == '0);
              a_raw    <= a;
`endif
              cnt   <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else begin
              ill <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
`ifdef ALU_MULDIV_DIV_EN
          if (is_mul) begin
            {hi, lo} <= prod;
          end else if (div_zero) begin
            lo <= '1;
            hi <= a_raw;
          end else begin
            lo <= q_fix;
            hi <= r_fix;
          end
          dbz <= div_zero;
`else
          {hi, lo} <= prod;
          dbz <= 1'b0;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH = 32): table vectors, hand-written
// handshake/reset sequences and randomized operations against a plain
// arithmetic reference model.
module tb_alu_muldiv;

  localparam int unsigned W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done, dbz, ill, zero;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference architectural state.
  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz), .ill(ill), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Updates the model for one accepted request; multi=1 for iterative ops.
  task automatic model_step(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                            output bit multi, output bit illg);
    longint      p;
    logic [63:0] up;
    int          q, r;
    multi = 1'b0;
    illg  = 1'b0;
    case (mop)
      3'd0: begin
        p = longint'($signed(ma)) * longint'($signed(mb));
        {m_hi, m_lo} = p;
        m_dbz = 1'b0; multi = 1'b1;
      end
      3'd1: begin
        up = {32'b0, ma} * {32'b0, mb};
        {m_hi, m_lo} = up;
        m_dbz = 1'b0; multi = 1'b1;
      end
      3'd2, 3'd3: begin
        if (!DIV_EN) begin
          illg = 1'b1;
        end else begin
          multi = 1'b1;
          m_dbz = (mb == 0);
          if (mb == 0) begin
            m_lo = '1; m_hi = ma;
          end else if (mop == 3'd3) begin
            m_lo = ma / mb; m_hi = ma % mb;
          end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000; m_hi = '0;
          end else begin
            q = $signed(ma) / $signed(mb);
            r = $signed(ma) % $signed(mb);
            m_lo = q; m_hi = r;
          end
        end
      end
      3'd4: m_hi = ma;
      3'd5: m_lo = ma;
      default: illg = 1'b1;
    endcase
  endtask

  // Issue one request in the current cycle and check it against the model.
  // Iterative ops return in the done cycle; single-cycle ops return in cycle 1.
  task automatic do_op(input logic [2:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    bit multi, illg;
    int busy_cnt, done_at;
    model_step(iop, ia, ib, multi, illg);
    start = 1'b1; op = iop; a = ia; b = ib;
    tick();
    start = 1'b0; a = $urandom(); b = $urandom();
    if (multi) begin
      busy_cnt = 0; done_at = 0;
      for (int c = 1; c <= int'(W) + 6 && done_at == 0; c++) begin
        if (busy) busy_cnt++;
        if (done) done_at = c;
        else tick();
      end
      check("done_cycle", 64'(done_at), 64'(W + 2));
      check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
      check("busy_with_done", {63'b0, busy}, 64'd0);
      check("hi", {32'b0, hi}, {32'b0, m_hi});
      check("lo", {32'b0, lo}, {32'b0, m_lo});
      check("dbz", {63'b0, dbz}, {63'b0, m_dbz});
      check("zero", {63'b0, zero}, {63'b0, (m_lo == 0)});
    end else begin
      check("ill", {63'b0, ill}, {63'b0, illg});
      check("busy_single", {63'b0, busy}, 64'd0);
      check("done_single", {63'b0, done}, 64'd0);
      check("hi_single", {32'b0, hi}, {32'b0, m_hi});
      check("lo_single", {32'b0, lo}, {32'b0, m_lo});
      check("dbz_single", {63'b0, dbz}, {63'b0, m_dbz});
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, e_hi, e_lo;
    logic         e_dbz;
  } vec_t;

  vec_t tbl[11];
  int   c;
  bit   mm, mi;

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[7]  = '{3'd3, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    tbl[8]  = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
    tbl[9]  = '{3'd2, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    tbl[10] = '{3'd1, 32'd0,         32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    tick(); tick();
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_flags", {59'b0, busy, done, dbz, ill, zero}, 64'd1);
    rst = 1'b0;
    tick();

    // Table vectors (DIV/DIVU fall back to the model when compiled out).
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b);
      if (DIV_EN || !(tbl[i].op inside {3'd2, 3'd3})) begin
        check($sformatf("tbl%0d_hi", i), {32'b0, hi}, {32'b0, tbl[i].e_hi});
        check($sformatf("tbl%0d_lo", i), {32'b0, lo}, {32'b0, tbl[i].e_lo});
        check($sformatf("tbl%0d_dbz", i), {63'b0, dbz}, {63'b0, tbl[i].e_dbz});
      end
    end

    // MTLO nonzero, MTHI, then MTLO 0 in the following cycle.
    do_op(3'd5, 32'd5, 32'd0);
    check("zero_nonzero_lo", {63'b0, zero}, 64'd0);
    do_op(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_cycle1", {32'b0, hi}, 64'h1234_5678);
    do_op(3'd5, 32'd0, 32'd0);
    check("mtlo_zero_lo", {32'b0, lo}, 64'd0);
    check("mtlo_zero_flag", {63'b0, zero}, 64'd1);

    // Reserved opcodes; ill must drop again the cycle after its pulse.
    do_op(3'd6, 32'hAAAA_5555, 32'd1);
    tick();
    check("ill_pulse_end", {63'b0, ill}, 64'd0);
    do_op(3'd7, 32'h5555_AAAA, 32'd2);

    // Requests while busy are ignored.
    model_step(3'd0, 32'd5, 32'hFFFF_FFFD, mm, mi);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'hFFFF_FFFD;
    tick(); start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    tick();
    op = 3'd0; a = 32'd7; b = 32'd9;
    tick(); start = 1'b0;
    c = 12;
    while (!done && c < 40) begin tick(); c++; end
    check("ignored_done_cycle", 64'(c), 64'(W + 2));
    check("ignored_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("ignored_lo", {32'b0, lo}, 64'hFFFF_FFF1);

    // Reset in cycle 20 of an iterative operation.
    start = 1'b1; op = DIV_EN ? 3'd3 : 3'd0; a = 32'd1000; b = 32'd7;
    tick(); start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    check("midrst_hi", {32'b0, hi}, 64'd0);
    check("midrst_lo", {32'b0, lo}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) c++;
      tick();
    end
    check("midrst_no_done", 64'(c), 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
